// File: rtl/shift_seq_counter.sv
// shift_seq_counter
//   Parametrised ring / Johnson shift-sequence counter. Produces a one-hot
//   (ring) or thermometer (Johnson) phase pattern with enable, direction
//   control, validated parallel load, a sequence-position index and a wrap
//   pulse when a step returns the pattern to its seed.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | first edge after reset: load seed for the sampled mode, step=0
//   RUN   | mode re-seed > legal load > illegal load (error) > step > hold
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   en        advance one step this cycle
//   mode      0 = ring, 1 = Johnson
//   dir       0 = shift toward MSB, 1 = shift toward LSB
//   load      parallel-load request
//   load_val  value to load (must be a member of the current sequence)
//   out       counter pattern (registered)
//   step      position of out within the sequence (registered)
//   wrap      one-cycle pulse: a step landed back on the seed
//   load_err  one-cycle pulse: load rejected, load_val not in the sequence
//
// WIDTH must be at least 2. STEP_W is derived and should not be overridden.
module shift_seq_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = $clog2(2*WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic [STEP_W-1:0] step,
  output logic              wrap,
  output logic              load_err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(1);

  state_t             state;
  logic               mode_q;

  logic [WIDTH-1:0]   shift_val;
  logic [STEP_W-1:0]  step_adv;
  logic               wrap_next;
  logic               load_ok;
  logic [STEP_W-1:0]  load_idx;
  int                 period;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return m ? '0 : RING_SEED;
  endfunction

  function automatic int count_ones(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  // Number of adjacent bit pairs that differ; a thermometer code has at most one.
  function automatic int count_edges(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      if (v[i] != v[i+1]) n = n + 1;
    end
    return n;
  endfunction

  function automatic int ring_pos(input logic [WIDTH-1:0] v);
    int p;
    p = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  function automatic logic pattern_ok(input logic [WIDTH-1:0] v, input logic m);
    if (m) return count_edges(v) <= 1;
    return count_ones(v) == 1;
  endfunction

  // Johnson: 0..0 1^k (incl. all-zero and all-one) sits at index k on the
  // filling half; 1^a 0^b with b >= 1 sits at W+b on the draining half.
  function automatic logic [STEP_W-1:0] pattern_idx(input logic [WIDTH-1:0] v,
                                                    input logic m);
    int ones;
    ones = count_ones(v);
    if (!m) return STEP_W'(ring_pos(v));
    if (v[0] || (v == '0)) return STEP_W'(ones);
    return STEP_W'(2*WIDTH - ones);
  endfunction

  always_comb begin
    shift_val = '0;
    if (!mode_q) begin
      shift_val = dir ? {out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1]};
    end else begin
      shift_val = dir ? {~out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], ~out[WIDTH-1]};
    end
  end

  always_comb begin
    period   = mode_q ? 2*WIDTH : WIDTH;
    step_adv = dir ? STEP_W'((int'(step) + period - 1) % period)
                   : STEP_W'((int'(step) + 1) % period);
  end

  always_comb begin
    wrap_next = (shift_val == seed_of(mode_q));
    load_ok   = pattern_ok(load_val, mode_q);
    load_idx  = pattern_idx(load_val, mode_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      out      <= '0;
      step     <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          out      <= seed_of(mode);
          step     <= '0;
          mode_q   <= mode;
          wrap     <= 1'b0;
          load_err <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          wrap     <= 1'b0;
          load_err <= 1'b0;
          if (mode != mode_q) begin
            // Re-seed wins over everything; a coincident load is silently dropped.
            out    <= seed_of(mode);
            step   <= '0;
            mode_q <= mode;
          end else if (load) begin
            if (load_ok) begin
              out  <= load_val;
              step <= load_idx;
            end else begin
              load_err <= 1'b1;
            end
          end else if (en) begin
            out  <= shift_val;
            step <= step_adv;
            wrap <= wrap_next;
          end
        end
      endcase
    end
  end

  // Once running, out is always a sequence member and step always names it.
  a_out_legal: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> pattern_ok(out, mode_q));
  a_step_tracks: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (step == pattern_idx(out, mode_q)));
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(wrap && load_err));

endmodule

// File: tb/tb_shift_seq_counter.sv
module tb_shift_seq_counter;
  localparam int W  = 4;
  localparam int SW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  out;
  logic [SW-1:0] step;
  logic          wrap, load_err;

  shift_seq_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .out(out), .step(step), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  o;
    logic [SW-1:0] s;
    logic          w;
    logic          e;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: the counter is a position on a circle of P points.
  bit m_init = 1'b1;
  bit m_mode = 1'b0;
  int m_pos  = 0;

  logic [W-1:0] jt [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};

  function automatic int period_of(input bit m);
    return m ? 2*W : W;
  endfunction

  // Pattern at position p: ring = one-hot at p; Johnson fills p ones from the
  // bottom, then drains from the bottom once p passes W.
  function automatic logic [W-1:0] seq_val(input bit m, input int p);
    int v;
    if (!m) v = 1 << p;
    else if (p <= W) v = (1 << p) - 1;
    else v = ((1 << W) - 1) & ~((1 << (p - W)) - 1);
    return W'(v);
  endfunction

  task automatic drive(input bit e, input bit md, input bit d, input bit ld,
                       input logic [W-1:0] lv);
    exp_t x;
    int   per;
    bit   found;
    int   idx;
    @(negedge clk);
    rst = 1'b0;
    en = e; mode = md; dir = d; load = ld; load_val = lv;
    x.w = 1'b0;
    x.e = 1'b0;
    if (m_init) begin
      m_mode = md; m_pos = 0; m_init = 1'b0;
    end else if (md != m_mode) begin
      m_mode = md; m_pos = 0;
    end else if (ld) begin
      per = period_of(m_mode);
      found = 1'b0;
      idx = 0;
      for (int p = 0; p < per; p++) begin
        if (seq_val(m_mode, p) == lv) begin
          found = 1'b1; idx = p;
        end
      end
      if (found) m_pos = idx;
      else x.e = 1'b1;
    end else if (e) begin
      per = period_of(m_mode);
      m_pos = d ? (m_pos + per - 1) % per : (m_pos + 1) % per;
      x.w = (m_pos == 0);
    end
    x.o = seq_val(m_mode, m_pos);
    x.s = SW'(m_pos);
    q.push_back(x);
  endtask

  always begin : monitor
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if ({out, step, wrap, load_err} !== x) begin
        fails++;
        $display("FAIL scoreboard t=%0t got out=%b step=%0d wrap=%b err=%b want out=%b step=%0d wrap=%b err=%b",
                 $time, out, step, wrap, load_err, x.o, x.s, x.w, x.e);
      end
    end
  end

  task automatic spot(input string nm, input logic [W-1:0] o, input int s,
                      input bit w, input bit e);
    @(posedge clk);
    #2;
    tests++;
    if (out !== o || step !== SW'(s) || wrap !== w || load_err !== e) begin
      fails++;
      $display("FAIL %s got out=%b step=%0d wrap=%b err=%b want out=%b step=%0d wrap=%b err=%b",
               nm, out, step, wrap, load_err, o, s, w, e);
    end
  endtask

  task automatic chk_reset(input string nm);
    tests++;
    if (out !== '0 || step !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL %s got out=%b step=%0d wrap=%b err=%b want all zero",
               nm, out, step, wrap, load_err);
    end
  endtask

  task automatic mid_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset(nm);
    m_init = 1'b1;
    @(posedge clk);
    #1;
    chk_reset({nm, "_held"});
  endtask

  initial begin
    bit           e, md, d, ld;
    logic [W-1:0] lv;

    #1 rst = 1'b1;
    #2 chk_reset("reset_state");

    // Ring up from seed
    drive(1, 0, 0, 0, '0); spot("t1_init", 4'b0001, 0, 0, 0);
    drive(1, 0, 0, 0, '0); spot("t1_s1", 4'b0010, 1, 0, 0);
    drive(1, 0, 0, 0, '0); spot("t1_s2", 4'b0100, 2, 0, 0);
    drive(1, 0, 0, 0, '0); spot("t1_s3", 4'b1000, 3, 0, 0);
    drive(1, 0, 0, 0, '0); spot("t1_wrap", 4'b0001, 0, 1, 0);

    // Johnson up from seed
    drive(1, 1, 0, 0, '0); spot("t2_reseed", 4'b0000, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 0, 0, '0);
      spot($sformatf("t2_j%0d", k), jt[k-1], k % 8, k == 8, 0);
    end

    // Down direction
    drive(1, 1, 1, 0, '0); spot("t3_jdn1", 4'b1000, 7, 0, 0);
    drive(1, 1, 1, 0, '0); spot("t3_jdn2", 4'b1100, 6, 0, 0);
    drive(0, 0, 0, 0, '0); spot("t3_ring_seed", 4'b0001, 0, 0, 0);
    drive(1, 0, 1, 0, '0); spot("t3_rdn", 4'b1000, 3, 0, 0);

    // Loads
    drive(0, 1, 0, 0, '0);       spot("t4_jseed", 4'b0000, 0, 0, 0);
    drive(0, 1, 0, 1, 4'b1110);  spot("t4_jload", 4'b1110, 5, 0, 0);
    drive(1, 1, 0, 1, 4'b0101);  spot("t4_jbad", 4'b1110, 5, 0, 1);
    drive(0, 1, 0, 0, '0);       spot("t4_err_clear", 4'b1110, 5, 0, 0);
    drive(0, 1, 0, 1, 4'b1111);  spot("t4_jall1", 4'b1111, 4, 0, 0);
    drive(0, 0, 0, 0, '0);       spot("t4_rseed", 4'b0001, 0, 0, 0);
    drive(0, 0, 0, 1, 4'b0100);  spot("t4_rload", 4'b0100, 2, 0, 0);
    drive(0, 0, 0, 1, 4'b0110);  spot("t4_rbad", 4'b0100, 2, 0, 1);
    drive(0, 0, 0, 1, 4'b0000);  spot("t4_rzero", 4'b0100, 2, 0, 1);

    // Mode change beats load and enable
    drive(1, 1, 0, 1, 4'b0011);  spot("t5_collide", 4'b0000, 0, 0, 0);

    // Reset mid-count, then INIT ignores en/load
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    mid_reset("t6_mid_reset");
    drive(1, 1, 0, 1, 4'b0111); spot("t6_init", 4'b0000, 0, 0, 0);
    drive(1, 1, 0, 0, '0);      spot("t6_after", 4'b0001, 1, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom % 4) != 0;
      md = (($urandom % 20) == 0) ? ~m_mode : m_mode;
      d  = $urandom % 2;
      ld = ($urandom % 6) == 0;
      if ($urandom % 2)
        lv = seq_val(md, $urandom_range(0, period_of(md) - 1));
      else
        lv = W'($urandom);
      drive(e, md, d, ld, lv);
      if (i == 200) mid_reset("rand_mid_reset");
    end

    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
